// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: register file geometry, forwarding stage indices, producer latencies.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pipeline_pkg;

  localparam int REG_AW = 5;
  localparam int NREG   = 2**REG_AW;

  // Forwarding mux select value meaning "take the register file read"
  localparam int FWD_SEL_RF = 0;

  // Forwarding stage indices, nearest first
  localparam int STG_EXMEM = 0;
  localparam int STG_MEMWB = 1;

  // Cycles from issue until a producer's result can be forwarded
  typedef enum logic [2:0] {
    LAT_ALU  = 3'd1,
    LAT_LOAD = 3'd2,
    LAT_MUL  = 3'd4
  } lat_e;

endpackage

// File: rtl/fwd_select.sv
// Priority encoder picking the nearest forwarding stage whose destination matches one EX source.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; output follows inputs every cycle.
module fwd_select #(
  parameter int NUM_FWD = 2,
  parameter int REG_AW  = 5,
  parameter int SEL_W   = $clog2(NUM_FWD + 1)
) (
  input  logic [REG_AW-1:0]         rs,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_rd,
  output logic [SEL_W-1:0]          sel
);

  // Scan farthest to nearest so the lowest matching stage index is the last to assign
  always_comb begin
    sel = SEL_W'(pipeline_pkg::FWD_SEL_RF);
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fwd_we[k] && (fwd_rd[k*REG_AW +: REG_AW] == rs) && (rs != '0)) begin
        sel = SEL_W'(k + 1);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX forwarding selects, per-register latency scoreboard driving the ID stall, and a stall-cycle counter.
// Latency: fwd_sel_o/stall_o combinational; scoreboard and counter update on the next clock edge.
// Backpressure: stall_o holds PC and IF/ID; a stalled or flushed ID instruction never reaches the scoreboard.
module fwd_hazard_unit #(
  parameter int  NUM_SRC = 2,
  parameter int  NUM_FWD = 2,
  parameter int  REG_AW  = pipeline_pkg::REG_AW,
  parameter int  MAX_LAT = 4,
  parameter int  STAT_W  = 32,
  localparam int NREG    = 2**REG_AW,
  localparam int CNT_W   = $clog2(MAX_LAT + 1),
  localparam int SEL_W   = $clog2(NUM_FWD + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      id_valid_i,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs_i,
  input  logic [NUM_SRC-1:0]        id_rs_used_i,
  input  logic                      id_we_i,
  input  logic [REG_AW-1:0]         id_rd_i,
  input  logic [CNT_W-1:0]          id_lat_i,
  input  logic                      flush_i,
  input  logic [NUM_SRC*REG_AW-1:0] ex_rs_i,
  input  logic [NUM_FWD-1:0]        fwd_we_i,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_rd_i,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o,
  output logic                      stall_o,
  output logic [NREG-1:0]           busy_o,
  output logic [STAT_W-1:0]         stall_cnt_o
);

  localparam logic [CNT_W-1:0] MAX_LAT_C = CNT_W'(MAX_LAT);

  // Remaining cycles until each register's pending result is forwardable; entry 0 stays zero
  logic [NREG-1:0][CNT_W-1:0] cnt;
  logic [CNT_W-1:0]           lat_c;
  logic                       issue;
  logic                       trk_we;
  logic                       raw;
  logic                       waw;

  // Clamp oversize latencies and qualify the scoreboard write
  always_comb begin
    lat_c  = (id_lat_i > MAX_LAT_C) ? MAX_LAT_C : id_lat_i;
    issue  = id_valid_i && !flush_i && !stall_o;
    trk_we = issue && id_we_i && (id_rd_i != '0) && (id_lat_i != '0);
  end

  // Hazard check against registered counts only, so the stall never depends on fwd_* inputs
  always_comb begin
    raw = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (id_rs_used_i[s] && (id_rs_i[s*REG_AW +: REG_AW] != '0) &&
          (cnt[id_rs_i[s*REG_AW +: REG_AW]] > CNT_W'(1))) begin
        raw = 1'b1;
      end
    end
    waw     = id_we_i && (id_rd_i != '0) && (cnt[id_rd_i] > lat_c);
    stall_o = id_valid_i && !flush_i && (raw || waw);
  end

  // Scoreboard: a new tracked write reloads the count, otherwise non-zero counts tick down
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt <= '0;
    end else begin
      cnt[0] <= '0;
      for (int r = 1; r < NREG; r++) begin
        if (trk_we && (id_rd_i == REG_AW'(r))) begin
          cnt[r] <= lat_c;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - CNT_W'(1);
        end
      end
    end
  end

  // Per-register pending flags
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      busy_o[r] = (cnt[r] != '0);
    end
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
    end else if (stall_o && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + STAT_W'(1);
    end
  end

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_sel
    fwd_select #(
      .NUM_FWD (NUM_FWD),
      .REG_AW  (REG_AW),
      .SEL_W   (SEL_W)
    ) u_fwd_select (
      .rs     (ex_rs_i[s*REG_AW +: REG_AW]),
      .fwd_we (fwd_we_i),
      .fwd_rd (fwd_rd_i),
      .sel    (fwd_sel_o[s*SEL_W +: SEL_W])
    );
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench: stimulus queues hand-computed expectations, a negedge monitor pops and compares.
// Latency: checks land in the same cycle the stimulus is applied (sampled at the falling edge).
// Backpressure: n/a.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_used;
  logic        id_we;
  logic [4:0]  id_rd;
  logic [2:0]  id_lat;
  logic        flush;
  logic [9:0]  ex_rs;
  logic [1:0]  fwd_we;
  logic [9:0]  fwd_rd;
  logic [3:0]  fwd_sel;
  logic        stall;
  logic [31:0] busy;
  logic [31:0] stall_cnt;
  logic [3:0]  fwd_sel_s;
  logic        stall_s;
  logic [31:0] busy_s;
  logic [3:0]  stall_cnt_s;

  always #5 clk = ~clk;

  fwd_hazard_unit u_dut (
    .clk_i(clk), .rst_i(rst_n), .id_valid_i(id_valid), .id_rs_i(id_rs),
    .id_rs_used_i(id_rs_used), .id_we_i(id_we), .id_rd_i(id_rd), .id_lat_i(id_lat),
    .flush_i(flush), .ex_rs_i(ex_rs), .fwd_we_i(fwd_we), .fwd_rd_i(fwd_rd),
    .fwd_sel_o(fwd_sel), .stall_o(stall), .busy_o(busy), .stall_cnt_o(stall_cnt)
  );

  // Narrow statistics counter copy, used to observe saturation
  fwd_hazard_unit #(.STAT_W(4)) u_dut_sat (
    .clk_i(clk), .rst_i(rst_n), .id_valid_i(id_valid), .id_rs_i(id_rs),
    .id_rs_used_i(id_rs_used), .id_we_i(id_we), .id_rd_i(id_rd), .id_lat_i(id_lat),
    .flush_i(flush), .ex_rs_i(ex_rs), .fwd_we_i(fwd_we), .fwd_rd_i(fwd_rd),
    .fwd_sel_o(fwd_sel_s), .stall_o(stall_s), .busy_o(busy_s), .stall_cnt_o(stall_cnt_s)
  );

  localparam logic [2:0] F_STALL = 3'd0, F_BUSY = 3'd1, F_SEL = 3'd2, F_CNT = 3'd3, F_SAT = 3'd4;

  typedef struct packed {
    logic [2:0]  field;
    logic [3:0]  tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_stalls = 0;

  function automatic string fname(input logic [2:0] f);
    case (f)
      F_STALL: return "stall_o";
      F_BUSY:  return "busy_o";
      F_SEL:   return "fwd_sel_o";
      F_CNT:   return "stall_cnt_o";
      F_SAT:   return "stall_cnt_o(sat)";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [31:0] actual(input logic [2:0] f);
    case (f)
      F_STALL: return {31'b0, stall};
      F_BUSY:  return busy;
      F_SEL:   return {28'b0, fwd_sel};
      F_CNT:   return stall_cnt;
      F_SAT:   return {28'b0, stall_cnt_s};
      default: return 32'hdead_beef;
    endcase
  endfunction

  // Monitor: drain every expectation queued for this cycle and compare against the DUT
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [31:0] a;
      e = exp_q.pop_front();
      a = actual(e.field);
      n_checks++;
      if (a !== e.val) begin
        n_fail++;
        $display("FAIL test%0d %s actual=%0h required=%0h", e.tag, fname(e.field), a, e.val);
      end
    end
  end

  task automatic expect_f(input logic [2:0] f, input logic [31:0] v, input logic [3:0] tag);
    exp_q.push_back('{field: f, tag: tag, val: v});
  endtask

  task automatic chk_stall(input logic e, input logic [3:0] tag);
    expect_f(F_STALL, {31'b0, e}, tag);
    if (e) exp_stalls++;
  endtask

  task automatic chk_cnt(input logic [3:0] tag);
    expect_f(F_CNT, exp_stalls, tag);
  endtask

  task automatic idle();
    id_valid = 1'b0; id_rs = '0; id_rs_used = '0; id_we = 1'b0; id_rd = '0;
    id_lat = '0; flush = 1'b0; ex_rs = '0; fwd_we = '0; fwd_rd = '0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic id_instr(input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used,
                          input logic we, input logic [4:0] rd, input logic [2:0] lat,
                          input logic fl);
    id_valid = 1'b1; id_rs = {rs1, rs0}; id_rs_used = used;
    id_we = we; id_rd = rd; id_lat = lat; flush = fl;
  endtask

  localparam logic [2:0] L_ALU  = 3'(pipeline_pkg::LAT_ALU);
  localparam logic [2:0] L_LOAD = 3'(pipeline_pkg::LAT_LOAD);
  localparam logic [2:0] L_MUL  = 3'(pipeline_pkg::LAT_MUL);

  initial begin
    idle();
    rst_n = 1'b0;
    // Reset state
    nxt();
    chk_stall(1'b0, 4'd0); expect_f(F_BUSY, 32'h0, 4'd0); chk_cnt(4'd0);
    expect_f(F_SAT, 32'h0, 4'd0); expect_f(F_SEL, 32'h0, 4'd0);

    // Test 1: reset in the middle of a pending multiply
    nxt(); rst_n = 1'b1;
    id_instr(5'd0, 5'd0, 2'b00, 1'b1, 5'd3, L_MUL, 1'b0);
    chk_stall(1'b0, 4'd1);
    nxt();
    expect_f(F_BUSY, 32'h0000_0008, 4'd1);
    nxt(); rst_n = 1'b0;
    id_instr(5'd3, 5'd0, 2'b01, 1'b0, 5'd0, 3'd0, 1'b0);
    chk_stall(1'b0, 4'd1); expect_f(F_BUSY, 32'h0, 4'd1); chk_cnt(4'd1);
    nxt(); rst_n = 1'b1;
    id_instr(5'd3, 5'd0, 2'b01, 1'b0, 5'd0, 3'd0, 1'b0);
    chk_stall(1'b0, 4'd1);

    // Test 2: ALU result consumed back to back, forwarded from EX/MEM
    nxt(); id_instr(5'd0, 5'd0, 2'b00, 1'b1, 5'd5, L_ALU, 1'b0);
    chk_stall(1'b0, 4'd2);
    nxt(); id_instr(5'd5, 5'd0, 2'b01, 1'b0, 5'd0, 3'd0, 1'b0);
    ex_rs = {5'd0, 5'd5}; fwd_we = 2'b01; fwd_rd = {5'd0, 5'd5};
    chk_stall(1'b0, 4'd2); expect_f(F_SEL, 32'h1, 4'd2);

    // Test 3: load-use costs one bubble; an unused source does not stall
    nxt(); id_instr(5'd0, 5'd0, 2'b00, 1'b1, 5'd7, L_LOAD, 1'b0);
    chk_stall(1'b0, 4'd3);
    nxt(); id_instr(5'd0, 5'd7, 2'b10, 1'b0, 5'd0, 3'd0, 1'b0);
    chk_cnt(4'd3); chk_stall(1'b1, 4'd3);
    nxt(); id_instr(5'd0, 5'd7, 2'b10, 1'b0, 5'd0, 3'd0, 1'b0);
    chk_cnt(4'd3); chk_stall(1'b0, 4'd3);
    nxt(); id_instr(5'd0, 5'd0, 2'b00, 1'b1, 5'd7, L_LOAD, 1'b0);
    chk_stall(1'b0, 4'd3);
    nxt(); id_instr(5'd0, 5'd7, 2'b01, 1'b0, 5'd0, 3'd0, 1'b0);
    chk_stall(1'b0, 4'd3);

    // Test 4: multiply consumer stalls three cycles; a flushed instruction neither stalls nor writes
    nxt(); id_instr(5'd0, 5'd0, 2'b00, 1'b1, 5'd3, L_MUL, 1'b0);
    chk_stall(1'b0, 4'd4);
    for (int i = 0; i < 4; i++) begin
      nxt(); id_instr(5'd3, 5'd0, 2'b01, 1'b0, 5'd0, 3'd0, 1'b0);
      if (i == 3) chk_cnt(4'd4);
      chk_stall(i != 3, 4'd4);
    end
    nxt(); id_instr(5'd0, 5'd0, 2'b00, 1'b1, 5'd3, L_MUL, 1'b0);
    chk_stall(1'b0, 4'd4);
    nxt(); id_instr(5'd3, 5'd0, 2'b01, 1'b1, 5'd10, L_MUL, 1'b1);
    chk_stall(1'b0, 4'd4);
    nxt();
    expect_f(F_BUSY, 32'h0000_0008, 4'd4);
    nxt(); nxt(); nxt();

    // Test 5: forwarding priority
    ex_rs = {5'd9, 5'd9}; fwd_we = 2'b11; fwd_rd = {5'd9, 5'd9};
    expect_f(F_SEL, 32'h5, 4'd5); expect_f(F_BUSY, 32'h0, 4'd5);
    nxt(); ex_rs = {5'd9, 5'd9}; fwd_we = 2'b10; fwd_rd = {5'd9, 5'd9};
    expect_f(F_SEL, 32'ha, 4'd5);
    nxt(); ex_rs = {5'd4, 5'd9}; fwd_we = 2'b11; fwd_rd = {5'd4, 5'd9};
    expect_f(F_SEL, 32'h9, 4'd5);
    nxt(); ex_rs = {5'd0, 5'd0}; fwd_we = 2'b11; fwd_rd = {5'd0, 5'd0};
    expect_f(F_SEL, 32'h0, 4'd5);

    // Test 6: WAW stall then reload; stall counter saturation
    nxt(); id_instr(5'd0, 5'd0, 2'b00, 1'b1, 5'd4, L_MUL, 1'b0);
    chk_stall(1'b0, 4'd6);
    for (int i = 0; i < 4; i++) begin
      nxt(); id_instr(5'd0, 5'd0, 2'b00, 1'b1, 5'd4, L_ALU, 1'b0);
      chk_stall(i != 3, 4'd6);
    end
    nxt();
    expect_f(F_BUSY, 32'h0000_0010, 4'd6); chk_cnt(4'd6);
    nxt();
    expect_f(F_BUSY, 32'h0, 4'd6);
    nxt(); id_instr(5'd0, 5'd0, 2'b00, 1'b1, 5'd3, L_MUL, 1'b0);
    chk_stall(1'b0, 4'd7);
    for (int i = 0; i < 28; i++) begin
      nxt(); id_instr(5'd3, 5'd0, 2'b01, 1'b1, 5'd3, L_MUL, 1'b0);
      chk_stall((i % 4) != 3, 4'd7);
    end
    nxt();
    chk_cnt(4'd7); expect_f(F_SAT, 32'hf, 4'd7);
    nxt();
    nxt();

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
Parametrised successor to the 5-stage forwarding logic. It combines three functions:
- N-stage, N-source priority forwarding-select generation for the EX stage.
- A per-register countdown scoreboard for variable-latency producers (ALU, load, multi-cycle mul) that raises the ID-stage stall.
- A saturating stall-cycle statistics counter.

It sits beside the hazard detection path and drives the EX operand muxes and the PC/IF-ID write enables.

Parameters:
NUM_SRC, 2, source operand ports per instruction.
NUM_FWD, 2, forwarding stages, index 0 = nearest (EX/MEM), then MEM/WB, ...
REG_AW, 5, register address width; NREG = 2**REG_AW.
MAX_LAT, 4, largest producer latency tracked; CNT_W = $clog2(MAX_LAT+1).
STAT_W, 32, stall counter width.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  asynchronous, active-low reset.
id_valid_i  in  1  ID holds a real instruction.
id_rs_i  in  NUM_SRC*REG_AW  ID source registers, port s at [s*REG_AW +: REG_AW].
id_rs_used_i  in  NUM_SRC  source s actually read.
id_we_i  in  1  ID instruction writes rd.
id_rd_i  in  REG_AW  ID destination.
id_lat_i  in  CNT_W  cycles after issue until result is forwardable (1 = ALU, 2 = load).
flush_i  in  1  squash the ID instruction this cycle.
ex_rs_i  in  NUM_SRC*REG_AW  EX-stage source registers.
fwd_we_i  in  NUM_FWD  stage k writes back.
fwd_rd_i  in  NUM_FWD*REG_AW  stage k destination.
fwd_sel_o  out  NUM_SRC*SEL_W  per-source mux select, SEL_W = $clog2(NUM_FWD+1); 0 = register file, k+1 = stage k.
stall_o  out  1  hold PC and IF/ID, bubble into EX.
busy_o  out  NREG  bit r = cnt[r] != 0.
stall_cnt_o  out  STAT_W  saturating count of stall cycles.

Behaviour:
Reset:
- rst_i low asynchronously clears all cnt[r] and stall_cnt_o.
- Consequently stall_o = 0, busy_o = 0, and fwd_sel_o depends only on its inputs.
- Reset asserted mid-stall drops stall_o in the same cycle.

Issue:
- issue = id_valid_i && !flush_i && !stall_o.
- Tracked write = issue && id_we_i && id_rd_i != 0 && id_lat_i != 0.
- id_lat_i > MAX_LAT is clamped to MAX_LAT.

Scoreboard, per register r (r = 0 is never tracked; cnt[0] is tied to 0):
- Tracked write to r: cnt[r] <= lat. This takes priority over the decrement.
- Otherwise, if cnt[r] != 0: cnt[r] <= cnt[r] - 1.
- Otherwise: hold 0.

stall_o (combinational from registered cnt; no combinational path from fwd_* inputs):
- stall_o = id_valid_i && !flush_i && (RAW || WAW).
- RAW: for any s, id_rs_used_i[s] && rs != 0 && cnt[rs] > 1.
- WAW: id_we_i && id_rd_i != 0 && cnt[id_rd_i] > clamped id_lat_i.
- Resulting stall lengths: load-use stalls exactly 1 cycle; a lat-L producer followed immediately by a consumer stalls L-1 cycles.

fwd_sel_o (combinational, per source s):
- Select the lowest k with fwd_we_i[k] && fwd_rd[k] == ex_rs[s] && ex_rs[s] != 0; output k+1.
- If no stage matches, output 0.
- The nearest stage wins on multiple matches.

stall_cnt_o:
- Increments when stall_o is 1.
- Holds at all-ones (no wrap).

Flush:
- Suppresses issue and stall for the ID instruction only.
- Leaves the scoreboard untouched.

Decomposition:
- pipeline_pkg: REG_AW, NREG, FWD_SEL_RF = 0, stage index constants (STG_EXMEM = 0, STG_MEMWB = 1), and a latency constants enum (LAT_ALU = 1, LAT_LOAD = 2, LAT_MUL = 4).
- Sub-module fwd_select: combinational priority encoder for one source over NUM_FWD stages, instantiated NUM_SRC times via generate.
- The scoreboard and stall counter stay in the top module.

Test Plan:
1. Reset: issue mul rd=3 lat 4, assert rst_i low 2 cycles later -> busy_o = 0, stall_o = 0, stall_cnt_o = 0 immediately; after release, consumer rs1=3 sees no stall.
2. ALU back-to-back: issue rd=5 lat 1; next cycle ID rs1=5 used -> stall_o = 0; EX with fwd_we_i[0]=1, fwd_rd[0]=5, ex_rs1=5 -> fwd_sel port0 = 1.
3. Load-use: issue rd=7 lat 2; next ID rs2=7 used -> stall_o = 1 for exactly 1 cycle, stall_cnt_o += 1; rs2=7 with id_rs_used_i[1]=0 -> no stall.
4. Multi-cycle: issue rd=3 lat 4; consumer rs1=3 -> stall 3 cycles, then issue; same consumer with flush_i=1 -> stall_o = 0 and cnt unaffected.
5. Forward priority: stages 0 and 1 both write rd=9, ex_rs=9 -> sel = 1; only stage 1 -> sel = 2; ex_rs=0 with stage rd=0 -> sel = 0.
6. WAW and saturation: pending rd=4 cnt=4, ID ALU rd=4 lat 1 -> stall until cnt[4] = 1, then cnt[4] reloads to 1; preload STAT_W=4 and stall 20 cycles -> stall_cnt_o holds 15.
